// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_pkg
// Brief   : Shared NoC types: flit, VC identifier, default link parameters.
// Revision: 1.0 - initial multi-VC release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W = 8;
    typedef logic [FLIT_W-1:0] flit_t;

    localparam int DEF_NUM_VC     = 2;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CREDITS    = 4;

    // Width of a VC index; a single-VC link still carries a 1-bit field
    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VC_W = vc_width(DEF_NUM_VC);
    typedef logic [VC_W-1:0] vc_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter, one-hot grant, search starts at rr_ptr.
//           The pointer moves past the winner only when advance is high.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    // Index p+off reduced modulo N without a divider (off <= N)
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return PTR_W'(s);
    endfunction

    // First requester at or above r_ptr, with wrap; winner+1 becomes the next start
    always_comb begin
        gnt        = '0;
        w_next_ptr = r_ptr;
        w_cand     = r_ptr;
        w_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_cand = wrap_add(r_ptr, i);
            if (!w_found && req[w_cand]) begin
                gnt[w_cand] = 1'b1;
                w_found     = 1'b1;
                w_next_ptr  = wrap_add(w_cand, 1);
            end
        end
    end

    // Pointer holds when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/node_port_vc_tx.sv
`default_nettype none
// ============================================================================
// Module  : node_port_vc_tx
// Brief   : Link transmit port with per-VC buffering, credit flow control and
//           round-robin VC arbitration; one registered flit per cycle.
// Revision: 1.0 - replaces single-channel enable/ack backpressure
// ============================================================================
module node_port_vc_tx
    import noc_pkg::*;
#(
    parameter int NUM_VC     = DEF_NUM_VC,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CREDITS    = DEF_CREDITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  flit_t                         in_flit,
    input  logic [NUM_VC-1:0]             in_valid,
    output logic [NUM_VC-1:0]             in_ready,
    output flit_t                         out_flit,
    output logic                          out_enable,
    output logic [vc_width(NUM_VC)-1:0]   out_vc,
    input  logic                          credit_valid,
    input  logic [vc_width(NUM_VC)-1:0]   credit_vc,
    output logic                          err_overflow
);

    localparam int OUT_VC_W = vc_width(NUM_VC);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W     = $clog2(CREDITS + 1);

    logic [NUM_VC-1:0]         w_eligible;
    logic [NUM_VC-1:0]         w_gnt;
    logic [NUM_VC-1:0]         w_ovf;
    flit_t [NUM_VC-1:0]        w_head;
    logic [OUT_VC_W-1:0]       w_gidx;
    logic                      w_any;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        flit_t            r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wr;
        logic [PTR_W-1:0] r_rd;
        logic [CNT_W-1:0] r_cnt;
        logic [CR_W-1:0]  r_credit;
        logic             w_push;
        logic             w_pop;
        logic             w_ret;

        // Ready comes from registered occupancy only, so a full FIFO stays
        // closed even in a cycle where it is popping
        assign in_ready[v]   = (r_cnt < CNT_W'(FIFO_DEPTH));
        assign w_push        = in_valid[v] && in_ready[v];
        assign w_pop         = w_gnt[v];
        assign w_ret         = credit_valid && (credit_vc == OUT_VC_W'(v));
        assign w_eligible[v] = (r_cnt != '0) && (r_credit != '0);
        assign w_head[v]     = r_mem[r_rd];
        // A grant in the same cycle absorbs the return, so only a bare
        // return onto a full counter is a protocol error
        assign w_ovf[v]      = w_ret && !w_pop && (r_credit == CR_W'(CREDITS));

        // Flit storage; contents are don't-care while the FIFO is empty
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= in_flit;
            end
        end

        // Read/write pointers wrap at FIFO_DEPTH-1, so any depth works
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= (r_wr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd <= (r_rd == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Credit counter: grant consumes, return restores, saturating at CREDITS
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_credit <= CR_W'(CREDITS);
            end else if (w_ret && !w_pop) begin
                if (r_credit != CR_W'(CREDITS)) begin
                    r_credit <= r_credit + CR_W'(1);
                end
            end else if (w_pop && !w_ret) begin
                r_credit <= r_credit - CR_W'(1);
            end
        end
    end

    rr_arbiter #(
        .N       (NUM_VC)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_eligible),
        .advance (w_any),
        .gnt     (w_gnt)
    );

    assign w_any = |w_eligible;

    // One-hot grant to a VC index
    always_comb begin
        w_gidx = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_gnt[v]) w_gidx = OUT_VC_W'(v);
        end
    end

    // Link output register; flit and VC hold their last value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_enable <= 1'b0;
            out_flit   <= '0;
            out_vc     <= '0;
        end else begin
            out_enable <= w_any;
            if (w_any) begin
                out_flit <= w_head[w_gidx];
                out_vc   <= w_gidx;
            end
        end
    end

    // Sticky credit-overflow flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (|w_ovf) begin
            err_overflow <= 1'b1;
        end
    end

    // The local source offers at most one VC per cycle
    a_in_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_valid));

endmodule
`default_nettype wire
